store_buffer: RTL and testbench

//  Posted-write buffer between the pipeline data port (dcache_*) and the data cache/TCM cpu_* port.

---
 rtl/store_buffer.sv | 175 +++++++++++++++++
 tb/tb_store_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write buffer between the pipeline data port and the cache port: stores retire into a
// small FIFO and drain in the background, while loads bypass unless they hit a buffered word.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int COALESCE   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [3:0]            cpu_wr_be,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  output logic                  cpu_waitrequest,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_rd,
  output logic                  cache_wr,
  output logic [3:0]            cache_wr_be,
  output logic [DATA_WIDTH-1:0] cache_wr_data,
  input  logic [DATA_WIDTH-1:0] cache_data,
  input  logic                  cache_waitrequest,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR_BUSY = 2'd1;
  localparam logic [1:0] S_RD_BUSY = 2'd2;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_d,
                                                        input logic [DATA_WIDTH-1:0] new_d,
                                                        input logic [3:0]            be);
    logic [DATA_WIDTH-1:0] r;
    r = old_d;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_d[8*b +: 8];
    return r;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [PTR_W-1:0]      head_q, tail_q, young;
  logic [PTR_W:0]        count_q, count_d;
  logic [DEPTH-1:0]      vld_q;
  logic [WA_W-1:0]       ent_addr [DEPTH];
  logic [3:0]            ent_be   [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [WA_W-1:0]       busy_addr_q;
  logic [3:0]            busy_be_q;
  logic [DATA_WIDTH-1:0] busy_data_q;
  logic                  empty_q;

  logic [WA_W-1:0] cpu_word;
  logic hazard, load_go, drain_go, head_busy, full, coal_hit, push, pop;

  assign cpu_word = cpu_addr[ADDR_WIDTH-1:2];
  assign young    = tail_q - PTR_W'(1);
  assign full     = (count_q == (PTR_W+1)'(DEPTH));

  // The draining entry stays valid until its transfer completes, so this also covers a drain in flight.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && ent_addr[i] == cpu_word) hazard = 1'b1;
  end

  assign load_go   = cpu_rd && !hazard && (state_q == S_IDLE);
  assign drain_go  = (state_q == S_IDLE) && !load_go && (count_q != '0);
  assign head_busy = drain_go || (state_q == S_WR_BUSY);
  assign coal_hit  = (COALESCE != 0) && cpu_wr && (count_q != '0) &&
                     (ent_addr[young] == cpu_word) && !((young == head_q) && head_busy);
  assign push      = cpu_wr && !coal_hit && !full;

  always_comb begin
    cache_rd      = 1'b0;
    cache_wr      = 1'b0;
    cache_addr    = '0;
    cache_wr_be   = '0;
    cache_wr_data = '0;
    case (state_q)
      S_IDLE: begin
        if (load_go) begin
          cache_rd   = 1'b1;
          cache_addr = {cpu_word, 2'b00};
        end else if (drain_go) begin
          cache_wr      = 1'b1;
          cache_addr    = {ent_addr[head_q], 2'b00};
          cache_wr_be   = ent_be[head_q];
          cache_wr_data = ent_data[head_q];
        end
      end
      S_WR_BUSY: begin
        cache_wr      = 1'b1;
        cache_addr    = {busy_addr_q, 2'b00};
        cache_wr_be   = busy_be_q;
        cache_wr_data = busy_data_q;
      end
      S_RD_BUSY: begin
        cache_rd   = 1'b1;
        cache_addr = {busy_addr_q, 2'b00};
      end
      default: ;
    endcase
  end

  assign pop         = cache_wr && !cache_waitrequest;
  assign cpu_rd_data = cache_rd ? cache_data : '0;

  always_comb begin
    cpu_waitrequest = 1'b0;
    if (cpu_rd)
      cpu_waitrequest = (state_q == S_WR_BUSY) || ((state_q == S_IDLE) && hazard) || cache_waitrequest;
    else if (cpu_wr)
      cpu_waitrequest = !coal_hit && full;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (load_go && cache_waitrequest) state_d = S_RD_BUSY;
                 else if (drain_go && cache_waitrequest) state_d = S_WR_BUSY;
      S_WR_BUSY: if (!cache_waitrequest) state_d = S_IDLE;
      S_RD_BUSY: if (!cache_waitrequest) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  // Control state: pointers, occupancy, FSM, registered empty flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      empty_q <= (count_d == '0) && (state_d != S_WR_BUSY);
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PTR_W'(1);
      end
    end
  end

  // Entry payload and the held transfer; meaningless while the matching control bits say so
  always_ff @(posedge clock) begin
    if (state_q == S_IDLE) begin
      busy_addr_q <= cache_addr[ADDR_WIDTH-1:2];
      busy_be_q   <= cache_wr_be;
      busy_data_q <= cache_wr_data;
    end
    if (push) begin
      ent_addr[tail_q] <= cpu_word;
      ent_be[tail_q]   <= cpu_wr_be;
      ent_data[tail_q] <= cpu_wr_data;
    end else if (coal_hit) begin
      ent_be[young]   <= ent_be[young] | cpu_wr_be;
      ent_data[young] <= merge_bytes(ent_data[young], cpu_wr_data, cpu_wr_be);
    end
  end

  assign empty = empty_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_store_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [3:0]  cpu_wr_be;
  logic [31:0] cpu_wr_data, cpu_rd_data;
  logic        cpu_waitrequest;
  logic [31:0] cache_addr;
  logic        cache_rd, cache_wr;
  logic [3:0]  cache_wr_be;
  logic [31:0] cache_wr_data, cache_data;
  logic        cache_waitrequest;
  logic        empty;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  store_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .COALESCE(1)) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wr_be(cpu_wr_be),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data), .cpu_waitrequest(cpu_waitrequest),
    .cache_addr(cache_addr), .cache_rd(cache_rd), .cache_wr(cache_wr), .cache_wr_be(cache_wr_be),
    .cache_wr_data(cache_wr_data), .cache_data(cache_data), .cache_waitrequest(cache_waitrequest),
    .empty(empty)
  );

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        cw;
    logic [31:0] cd;
    logic        e_wait, e_crd, e_cwr;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rdd;
    logic        e_emp;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic rd, wr, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input logic cw, input logic [31:0] cd,
                              input logic e_wait, e_crd, e_cwr, input logic [31:0] e_addr,
                              input logic [3:0] e_be, input logic [31:0] e_wd, e_rdd,
                              input logic e_emp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wd = wd; v.cw = cw; v.cd = cd;
    v.e_wait = e_wait; v.e_crd = e_crd; v.e_cwr = e_cwr; v.e_addr = e_addr;
    v.e_be = e_be; v.e_wd = e_wd; v.e_rdd = e_rdd; v.e_emp = e_emp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input logic rd, wr, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic w, input logic [31:0] cdat);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wr_be = b; cpu_wr_data = d;
    cache_waitrequest = w; cache_data = cdat;
  endtask

  // Drive at the falling edge, sample 1 time unit later (well before the next rising edge)
  task automatic step(input logic rd, wr, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic w, input logic [31:0] cdat);
    @(negedge clock);
    drive(rd, wr, a, b, d, w, cdat);
    #1;
  endtask

  initial begin
    int nd;
    logic [31:0] exp_drain [3];

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst.wait",  32'(cpu_waitrequest), 0);
    chk("rst.crd",   32'(cache_rd), 0);
    chk("rst.cwr",   32'(cache_wr), 0);
    chk("rst.addr",  cache_addr, 0);
    chk("rst.be",    32'(cache_wr_be), 0);
    chk("rst.wdata", cache_wr_data, 0);
    chk("rst.rdata", cpu_rd_data, 0);
    chk("rst.empty", 32'(empty), 1);

    vt[0]  = mk(0,1,32'h100,4'hF,32'hDEADBEEF,0,0,   0,0,0,0,0,0,0,1);
    vt[1]  = mk(0,0,0,0,0,0,0,                        0,0,1,32'h100,4'hF,32'hDEADBEEF,0,0);
    vt[2]  = mk(0,0,0,0,0,0,0,                        0,0,0,0,0,0,0,1);
    vt[3]  = mk(0,1,32'h180,4'hF,32'hAAAAAAAA,1,0,   0,0,0,0,0,0,0,1);
    vt[4]  = mk(0,1,32'h200,4'h1,32'h11,1,0,         0,0,1,32'h180,4'hF,32'hAAAAAAAA,0,0);
    vt[5]  = mk(0,1,32'h202,4'h4,32'h00330000,1,0,   0,0,1,32'h180,4'hF,32'hAAAAAAAA,0,0);
    vt[6]  = mk(0,0,0,0,0,0,0,                        0,0,1,32'h180,4'hF,32'hAAAAAAAA,0,0);
    vt[7]  = mk(0,0,0,0,0,0,0,                        0,0,1,32'h200,4'h5,32'h00330011,0,0);
    vt[8]  = mk(0,0,0,0,0,0,0,                        0,0,0,0,0,0,0,1);
    vt[9]  = mk(0,1,32'h403,4'hF,32'h44444444,0,0,   0,0,0,0,0,0,0,1);
    vt[10] = mk(1,0,32'h502,0,0,0,32'h55AA55AA,      0,1,0,32'h500,0,0,32'h55AA55AA,0);
    vt[11] = mk(0,0,0,0,0,0,0,                        0,0,1,32'h400,4'hF,32'h44444444,0,0);
    vt[12] = mk(0,0,0,0,0,0,0,                        0,0,0,0,0,0,0,1);

    for (int i = 0; i < 13; i++) begin
      step(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].be, vt[i].wd, vt[i].cw, vt[i].cd);
      chk($sformatf("v%0d.wait", i),  32'(cpu_waitrequest), 32'(vt[i].e_wait));
      chk($sformatf("v%0d.crd", i),   32'(cache_rd),        32'(vt[i].e_crd));
      chk($sformatf("v%0d.cwr", i),   32'(cache_wr),        32'(vt[i].e_cwr));
      chk($sformatf("v%0d.addr", i),  cache_addr,           vt[i].e_addr);
      chk($sformatf("v%0d.be", i),    32'(cache_wr_be),     32'(vt[i].e_be));
      chk($sformatf("v%0d.wdata", i), cache_wr_data,        vt[i].e_wd);
      chk($sformatf("v%0d.rdata", i), cpu_rd_data,          vt[i].e_rdd);
      chk($sformatf("v%0d.empty", i), 32'(empty),           32'(vt[i].e_emp));
    end

    // Fill to capacity under a stalled cache; the fifth store waits for a slot
    step(0,1,32'h1000,4'hF,32'h1,1,0);  chk("full.s0", 32'(cpu_waitrequest), 0);
    step(0,1,32'h1004,4'hF,32'h2,1,0);  chk("full.s1", 32'(cpu_waitrequest), 0);
    step(0,1,32'h1008,4'hF,32'h3,1,0);  chk("full.s2", 32'(cpu_waitrequest), 0);
    step(0,1,32'h100C,4'hF,32'h4,1,0);  chk("full.s3", 32'(cpu_waitrequest), 0);
    step(0,1,32'h1010,4'hF,32'h5,1,0);  chk("full.s4a", 32'(cpu_waitrequest), 1);
    step(0,1,32'h1010,4'hF,32'h5,1,0);  chk("full.s4b", 32'(cpu_waitrequest), 1);
    step(0,1,32'h1010,4'hF,32'h5,0,0);
    chk("full.s4c", 32'(cpu_waitrequest), 1);
    chk("full.d0cwr", 32'(cache_wr), 1);
    chk("full.d0addr", cache_addr, 32'h1000);
    step(0,1,32'h1010,4'hF,32'h5,0,0);
    chk("full.s4d", 32'(cpu_waitrequest), 0);
    chk("full.d1addr", cache_addr, 32'h1004);
    exp_drain[0] = 32'h1008; exp_drain[1] = 32'h100C; exp_drain[2] = 32'h1010;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      step(0,0,0,0,0,0,0);
      if (cache_wr) begin
        if (nd < 3) chk($sformatf("full.drain%0d", nd), cache_addr, exp_drain[nd]);
        nd++;
      end
    end
    chk("full.ndrain", 32'(nd), 3);
    chk("full.empty", 32'(empty), 1);

    // Load hitting a buffered word stalls until that word has drained
    step(0,1,32'h300,4'hF,32'h30303030,1,0);  chk("haz.st", 32'(cpu_waitrequest), 0);
    step(1,0,32'h300,0,0,1,0);
    chk("haz.w0", 32'(cpu_waitrequest), 1);
    chk("haz.crd0", 32'(cache_rd), 0);
    step(1,0,32'h300,0,0,1,0);
    chk("haz.w1", 32'(cpu_waitrequest), 1);
    chk("haz.crd1", 32'(cache_rd), 0);
    step(1,0,32'h300,0,0,0,0);
    chk("haz.w2", 32'(cpu_waitrequest), 1);
    chk("haz.cwr2", 32'(cache_wr), 1);
    step(1,0,32'h300,0,0,0,32'h30303030);
    chk("haz.w3", 32'(cpu_waitrequest), 0);
    chk("haz.crd3", 32'(cache_rd), 1);
    chk("haz.addr3", cache_addr, 32'h300);
    chk("haz.rdata3", cpu_rd_data, 32'h30303030);

    // Load held by the cache stays presented until the cache accepts it
    step(1,0,32'h600,0,0,1,0);
    chk("rdb.w0", 32'(cpu_waitrequest), 1);
    chk("rdb.crd0", 32'(cache_rd), 1);
    step(1,0,32'h600,0,0,1,0);
    chk("rdb.crd1", 32'(cache_rd), 1);
    chk("rdb.addr1", cache_addr, 32'h600);
    step(1,0,32'h600,0,0,0,32'h66);
    chk("rdb.w2", 32'(cpu_waitrequest), 0);
    chk("rdb.rdata2", cpu_rd_data, 32'h66);

    // Reset during a held drain with three entries buffered
    step(0,1,32'h700,4'hF,32'h7,1,0);
    step(0,1,32'h704,4'hF,32'h8,1,0);
    step(0,1,32'h708,4'hF,32'h9,1,0);
    chk("rstb.busy", 32'(cache_wr), 1);
    @(negedge clock);
    reset = 1'b1;
    drive(0,0,0,0,0,1,0);
    @(negedge clock);
    reset = 1'b0;
    drive(0,0,0,0,0,0,0);
    #1;
    chk("rstb.cwr", 32'(cache_wr), 0);
    chk("rstb.empty", 32'(empty), 1);
    nd = 0;
    for (int k = 0; k < 5; k++) begin
      step(0,0,0,0,0,0,0);
      if (cache_wr) nd++;
    end
    chk("rstb.nodrain", 32'(nd), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
